// File: rtl/mux_datapath_mac_pkg.sv
// Shared definitions for the MAC datapath: default widths, operand select codes,
// FSM state encoding and the fixed coefficient table K[0..7].
// Latency: n/a (definitions only). Backpressure: n/a.
package mux_datapath_mac_pkg;

  localparam int W_DEF    = 16;
  localparam int FRAC_DEF = 8;

  // Operand A source selected by sel_fun
  typedef enum logic [1:0] {
    FUN_X   = 2'b00,  // X register
    FUN_ACC = 2'b01,  // accumulator
    FUN_Y   = 2'b10,  // published result y_out
    FUN_ONE = 2'b11   // constant 1.0
  } sel_fun_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2
  } state_e;

  // Coefficient table, Q8.8 encoding
  function automatic logic [15:0] coef(input logic [2:0] idx);
    logic [15:0] k;
    k = 16'h0000;
    case (idx)
      3'd0: k = 16'h0100;  // 1.0
      3'd1: k = 16'h0080;  // 0.5
      3'd2: k = 16'hFF00;  // -1.0
      3'd3: k = 16'h0200;  // 2.0
      3'd4: k = 16'h0040;  // 0.25
      3'd5: k = 16'h7FFF;  // largest positive
      3'd6: k = 16'h8000;  // most negative
      default: k = 16'h0000;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/mux_datapath_mac_round_sat.sv
// Combinational round-half-up by 2^FRAC followed by saturation to signed W bits.
// Latency: 0 cycles (pure combinational). Backpressure: none, always ready.
// Ports: din_i (IN_W signed input), dout_o (W signed rounded/saturated result).
module round_sat #(
  parameter int IN_W = 32,
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic signed [IN_W-1:0] din_i,
  output logic signed [W-1:0]    dout_o
);

  // One guard bit so the rounding bias can never wrap the input range
  logic signed [IN_W:0] biased;
  logic signed [IN_W:0] shifted;
  logic                 fits;

  generate
    if (FRAC > 0) begin : g_round
      assign biased = {din_i[IN_W-1], din_i} + ((IN_W+1)'(1) << (FRAC-1));
    end else begin : g_pass
      assign biased = {din_i[IN_W-1], din_i};
    end
  endgenerate

  // Arithmetic shift gives floor, so bias + floor = round half up
  assign shifted = biased >>> FRAC;

  // Value fits in W bits when every bit above the W-bit sign matches it
  assign fits = (shifted[IN_W:W-1] == {(IN_W-W+2){shifted[W-1]}});

  always_comb begin
    dout_o = shifted[W-1:0];
    if (!fits) begin
      dout_o = shifted[IN_W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/mux_datapath_mac.sv
// Fixed-point MAC datapath: A (X/acc/y/1.0) x K[sel_const], rounded+saturated, loaded or accumulated.
// Latency: acc written 2 edges after op_en acceptance; fin copies acc to y_out 1 edge later (or after the op).
// Backpressure: none queued; op_en while busy is dropped, fin while busy is held pending until the write.
// Ports: clk, rst (async active-low); x_in/x_valid load X; op_en, sel_fun, sel_const, sel_acum launch an op;
//        fin publishes acc on y_out with a y_valid pulse; bandera pulses per completed op; busy while in flight.
module mux_datapath_mac
  import mux_datapath_mac_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] x_in,
  input  logic                x_valid,
  input  logic                op_en,
  input  logic [2:0]          sel_const,
  input  logic [1:0]          sel_fun,
  input  logic                sel_acum,
  input  logic                fin,
  output logic signed [W-1:0] y_out,
  output logic                y_valid,
  output logic                bandera,
  output logic                busy
);

  localparam logic [W-1:0] ONE_V = {{(W-1){1'b0}}, 1'b1} << FRAC;

  state_e                state_q;
  logic signed [W-1:0]   x_q, acc_q, y_q, a_q, k_q;
  logic signed [2*W-1:0] p_q;
  logic                  acum_q;
  logic                  pend_q;    // fin seen while an op was in flight
  logic                  y_req_q;   // copy acc to y_out on the next edge
  logic                  y_valid_q, bandera_q, busy_q;

  logic signed [W-1:0]   a_d, k_d, acc_d;
  logic signed [W-1:0]   r_prod, r_sum;
  logic signed [W:0]     sum_w;

  // Operand capture muxes, sampled only on acceptance in IDLE
  always_comb begin
    a_d = ONE_V;
    case (sel_fun_e'(sel_fun))
      FUN_X:   a_d = x_q;
      FUN_ACC: a_d = acc_q;
      FUN_Y:   a_d = y_q;
      default: a_d = ONE_V;
    endcase
  end

  assign k_d = W'($signed(coef(sel_const)));

  round_sat #(.IN_W(2*W), .W(W), .FRAC(FRAC)) u_rs_prod (
    .din_i  (p_q),
    .dout_o (r_prod)
  );

  // Accumulate sum in W+1 bits, then clamp with no rounding
  assign sum_w = {acc_q[W-1], acc_q} + {r_prod[W-1], r_prod};

  round_sat #(.IN_W(W+1), .W(W), .FRAC(0)) u_rs_sum (
    .din_i  (sum_w),
    .dout_o (r_sum)
  );

  assign acc_d = acum_q ? r_sum : r_prod;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      a_q       <= '0;
      k_q       <= '0;
      p_q       <= '0;
      acum_q    <= 1'b0;
      pend_q    <= 1'b0;
      y_req_q   <= 1'b0;
      y_valid_q <= 1'b0;
      bandera_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      bandera_q <= 1'b0;
      y_req_q   <= 1'b0;

      if (x_valid) x_q <= x_in;

      // acc is never written on the same edge a copy fires, so this sees a stable acc
      if (y_req_q) begin
        y_q       <= acc_q;
        y_valid_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (op_en) begin
            a_q     <= a_d;
            k_q     <= k_d;
            acum_q  <= sel_acum;
            pend_q  <= fin;
            busy_q  <= 1'b1;
            state_q <= ST_MUL;
          end else if (fin) begin
            y_req_q <= 1'b1;
          end
        end
        ST_MUL: begin
          p_q     <= (2*W)'(a_q) * (2*W)'(k_q);
          if (fin) pend_q <= 1'b1;
          state_q <= ST_ACC;
        end
        ST_ACC: begin
          acc_q     <= acc_d;
          bandera_q <= 1'b1;
          y_req_q   <= pend_q | fin;
          pend_q    <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign y_out   = y_q;
  assign y_valid = y_valid_q;
  assign bandera = bandera_q;
  assign busy    = busy_q;

endmodule

// File: doc/mux_datapath_mac.md
# mux_datapath_mac

Fixed-point multiply-accumulate datapath steered by the ControlMux select lines. `sel_fun` picks the multiplicand source and `sel_const` picks a coefficient from a constant table. `sel_acum` chooses between loading and accumulating the rounded, saturated product. The block returns `bandera` to the controller when each operation completes, and publishes the accumulator on `y_out` when `fin` is given, so it closes the control/datapath loop of the function evaluator.

## Interface
- `W`, 16: data width, signed two's complement.
- `FRAC`, 8: fractional bits (Q8.8 at defaults).
- `clk`  in  1: single clock; all state on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `x_in`  in  W: input sample.
- `x_valid`  in  1: loads `x_in` into the X register.
- `op_en`  in  1: launch one operation with the current selects.
- `sel_const`  in  3: coefficient index into K[0..7].
- `sel_fun`  in  2: operand A select.
  - 00 = X register
  - 01 = accumulator
  - 10 = `y_out`
  - 11 = constant 1.0 (`1<<FRAC`)
- `sel_acum`  in  1: 0 = acc ← product; 1 = acc ← sat(acc + product).
- `fin`  in  1: end of evaluation; copy acc to `y_out`.
- `y_out`  out  W: result register.
- `y_valid`  out  1: one-cycle pulse when `y_out` updates.
- `bandera`  out  1: one-cycle pulse when an operation has written acc.
- `busy`  out  1: high while an operation is in flight.

## Operation
- FSM states: IDLE, MUL, ACC.
  - IDLE → MUL on `op_en`.
  - MUL → ACC unconditionally.
  - ACC → IDLE unconditionally.
- On acceptance in IDLE, the block captures operand A, K[`sel_const`] and `sel_acum`. Later changes to the selects or to X do not affect the operation in flight.
- MUL: registers the 2W-bit signed product P = A × K.
- ACC: computes R as follows, then writes acc and pulses `bandera`.
  - R = (P + 2^(FRAC-1)) >>> FRAC, i.e. round half up.
  - R is saturated to [−2^(W-1), 2^(W-1)−1].
  - If `sel_acum` = 1: acc ← sat(acc + R), with the sum computed in W+1 bits.
  - If `sel_acum` = 0: acc ← R.
- `op_en` while `busy` is ignored; it is not queued.
- `fin` in IDLE with no `op_en`: `y_out` ← acc and `y_valid` pulses.
- `fin` in MUL or ACC, or together with an accepted `op_en`: the block sets a pending flag and performs the copy in the cycle after the ACC write, so `y_out` receives the post-operation acc.
- `x_valid` loads X in any state.
- Reset values:
  - `y_out`, acc, X and P = 0.
  - `y_valid`, `bandera` and `busy` = 0.
  - pending flag cleared; FSM in IDLE.
- `rst` low mid-operation aborts the operation immediately. No `bandera` is produced.

## Timing
- `op_en` sampled at edge t:
  - `busy` is high from t+1 through t+2.
  - acc is updated at edge t+2, with `bandera` high during the following cycle.
  - The next `op_en` is accepted at edge t+3.
- `fin` in IDLE at edge t: `y_out` and `y_valid` are valid after edge t+1.
- Pending `fin` (operation accepted at t): `y_out` updates at edge t+3.
- Throughput is one operation per 3 cycles.
- A `sel_fun` = 01 launch at edge t+3 sees the acc written at t+2. No bypass is needed.

## Structure
- Shared package contains:
  - W/FRAC defaults.
  - `sel_fun` encodings.
  - FSM state encoding.
  - Coefficient table K:
    - K0=0x0100 (1.0), K1=0x0080 (0.5), K2=0xFF00 (−1.0), K3=0x0200 (2.0)
    - K4=0x0040 (0.25), K5=0x7FFF, K6=0x8000, K7=0x0000
- One sub-module, `round_sat`: a combinational round-half-up plus saturate stage, parameterised by input width, W and FRAC. It is instantiated once for the product and once for the accumulate sum.

## Test plan
- Reset and abort: drive `rst` low during MUL. Required: all outputs 0, no `bandera` follows; after release, `op_en` with `sel_fun`=11, K0, `sel_acum`=0 gives acc = 0x0100.
- Load: `x_in`=0x0300 with `x_valid`, then `op_en` with `sel_fun`=00, `sel_const`=1, `sel_acum`=0. Required: `bandera` 2 cycles later; then `fin` gives `y_out`=0x0180 and `y_valid` for one cycle.
- Accumulate: from the previous state, `op_en` with `sel_fun`=00, `sel_const`=3, `sel_acum`=1. Required: acc = 0x0180 + 0x0600 = 0x0780; then `sel_fun`=01, K2, `sel_acum`=0 gives acc = 0xF880.
- Saturation, positive: X=0x7000 × K3 gives 0x7FFF; accumulating again stays 0x7FFF.
- Saturation, negative: X=0x8000 × K2 gives 0x7FFF; X=0x8000 × K3 gives 0x8000.
- Rounding: X=0x0001 × K1 gives 0x0001; X=0xFFFF × K1 gives 0x0000; X=0xFFFD × K1 gives 0xFFFF.
- Handshake collisions:
  - `op_en` asserted during MUL and ACC is ignored; exactly one `bandera` is produced.
  - `fin` during MUL gives `y_valid` at edge t+3 with the post-operation acc.
  - Simultaneous `op_en` and `fin` in IDLE behave the same way.
